// File: rtl/can_arb_pkg.sv
// Shared types and counter widths for the CAN TX push-port arbiter.
package can_arb_pkg;

    localparam int unsigned SENT_CNT_W = 16;
    localparam int unsigned GAP_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/can_tx_arbiter_if.sv
// Requester and CAN TX-buffer push-port bundle for can_tx_arbiter.
interface can_tx_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 64
);
    import can_arb_pkg::*;

    localparam int unsigned IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*DW-1:0]   req_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DW-1:0]         tx_data;
    logic [IDW-1:0]        grant_id;
    logic                  busy;
    logic [SENT_CNT_W-1:0] sent_cnt;

    // Arbiter side
    modport slave (
        input  req_valid, req_data, tx_ready,
        output req_ready, tx_valid, tx_data, grant_id, busy, sent_cnt
    );

    // Requesters plus CAN controller side
    modport master (
        output req_valid, req_data, tx_ready,
        input  req_ready, tx_valid, tx_data, grant_id, busy, sent_cnt
    );

endinterface

// File: rtl/can_rr_picker.sv
// Combinational round-robin scan starting at rr_ptr_i.
// CAN_TX_ARB_HIPRI_EN: requester 0 overrides the scan whenever it is valid.
module can_rr_picker
    import can_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic [$clog2(N_REQ)-1:0] grant_idx_o
);
    localparam int unsigned IW = $clog2(N_REQ);

`ifdef CAN_TX_ARB_HIPRI_EN
    localparam bit HIPRI = 1'b1;
`else
    localparam bit HIPRI = 1'b0;
`endif

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = '0;
        if (HIPRI && req_valid_i[0]) begin
            grant_o[0] = 1'b1;
            found      = 1'b1;
        end
        // First valid requester at or above the pointer, wrapping modulo N_REQ
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = IW'((32'(rr_ptr_i) + k) % N_REQ);
            if (!found && req_valid_i[idx] && !(HIPRI && idx == '0)) begin
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/can_tx_arbiter.sv
// Round-robin arbiter sharing the CAN TX-buffer push port among N_REQ requesters.
// CAN_TX_ARB_HIPRI_EN: requester 0 is strict high priority and does not advance rr_ptr.
module can_tx_arbiter
    import can_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DW         = 64,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    can_tx_arbiter_if.slave  arb_if
);
    localparam int unsigned IDW = $clog2(N_REQ);

    arb_state_t            state_q, state_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [DW-1:0]         tx_data_q, tx_data_d;
    logic [IDW-1:0]        grant_id_q, grant_id_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                  busy_q, busy_d;
    logic [SENT_CNT_W-1:0] sent_cnt_q, sent_cnt_d;
    logic [GAP_CNT_W-1:0]  gap_cnt_q, gap_cnt_d;

    logic [N_REQ-1:0]      grant;
    logic [IDW-1:0]        grant_idx;
    logic [DW-1:0]         win_word;
    logic [N_REQ-1:0]      req_ready_c;
    logic                  rr_adv;

    can_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req_valid_i (arb_if.req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

`ifdef CAN_TX_ARB_HIPRI_EN
    assign rr_adv = (grant_id_q != '0);
`else
    assign rr_adv = 1'b1;
`endif

    // Winner's word selected by the one-hot grant
    always_comb begin
        win_word = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) win_word = arb_if.req_data[i*DW +: DW];
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        sent_cnt_d  = sent_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        req_ready_c = '0;
        case (state_q)
            IDLE: begin
                req_ready_c = rst ? '0 : grant;
                if (|grant) begin
                    tx_data_d  = win_word;
                    grant_id_d = grant_idx;
                    tx_valid_d = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (tx_valid_q && arb_if.tx_ready) begin
                    tx_valid_d = 1'b0;
                    sent_cnt_d = sent_cnt_q + SENT_CNT_W'(1);
                    if (rr_adv) rr_ptr_d = IDW'((32'(grant_id_q) + 1) % N_REQ);
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        gap_cnt_d = GAP_CNT_W'(GAP_CYCLES - 1);
                        state_d   = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) state_d = IDLE;
                else                 gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            busy_q     <= 1'b0;
            sent_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            busy_q     <= busy_d;
            sent_cnt_q <= sent_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign arb_if.req_ready = req_ready_c;
    assign arb_if.tx_valid  = tx_valid_q;
    assign arb_if.tx_data   = tx_data_q;
    assign arb_if.grant_id  = grant_id_q;
    assign arb_if.busy      = busy_q;
    assign arb_if.sent_cnt  = sent_cnt_q;

endmodule

// File: tb/tb_can_tx_arbiter.sv
// Self-checking bench for can_tx_arbiter: one instance with GAP_CYCLES=4, one with 0.
// Expectations honour CAN_TX_ARB_HIPRI_EN when it is defined for the build.
module tb_can_tx_arbiter;

    localparam int unsigned NR    = 4;
    localparam int unsigned DW    = 64;
    localparam int unsigned GAP_A = 4;
    localparam int unsigned GAP_B = 0;

`ifdef CAN_TX_ARB_HIPRI_EN
    localparam bit HIPRI = 1'b1;
`else
    localparam bit HIPRI = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    can_tx_arbiter_if #(.N_REQ(NR), .DW(DW)) bus_a ();
    can_tx_arbiter_if #(.N_REQ(NR), .DW(DW)) bus_b ();

    can_tx_arbiter #(.N_REQ(NR), .DW(DW), .GAP_CYCLES(GAP_A)) dut_a (
        .clk(clk), .rst(rst), .arb_if(bus_a));
    can_tx_arbiter #(.N_REQ(NR), .DW(DW), .GAP_CYCLES(GAP_B)) dut_b (
        .clk(clk), .rst(rst), .arb_if(bus_b));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] wd_b [NR];

    // Reference arbitration rule: first valid requester from rr upward, modulo NR
    function automatic int pick(logic [NR-1:0] v, int rr);
        if (HIPRI && v[0]) return 0;
        for (int k = 0; k < int'(NR); k++) begin
            int i;
            i = (rr + k) % int'(NR);
            if (HIPRI && i == 0) continue;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic int rr_next(int g, int rr);
        if (HIPRI && g == 0) return rr;
        return (g + 1) % int'(NR);
    endfunction

    function automatic logic [NR-1:0] onehot(int w);
        if (w < 0) return '0;
        return NR'(1) << w;
    endfunction

    task automatic drive_b();
        for (int i = 0; i < int'(NR); i++) bus_b.req_data[i*DW +: DW] = wd_b[i];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_b.req_valid = '0;
        bus_b.req_data  = '0;
        bus_b.tx_ready  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus_b.req_valid = 4'b1111;
        #1;
        n_checks++;
        if ({bus_b.tx_valid, bus_b.tx_data, bus_b.grant_id, bus_b.busy, bus_b.sent_cnt, bus_b.req_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_b: tx_valid=%b tx_data=%h grant=%0d busy=%b cnt=%0d ready=%b, want all 0",
                     bus_b.tx_valid, bus_b.tx_data, bus_b.grant_id, bus_b.busy, bus_b.sent_cnt, bus_b.req_ready);
        end
        bus_b.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus_a.tx_valid, bus_a.tx_data, bus_a.grant_id, bus_a.busy, bus_a.sent_cnt, bus_a.req_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: tx_valid=%b tx_data=%h grant=%0d busy=%b cnt=%0d ready=%b, want all 0",
                     bus_a.tx_valid, bus_a.tx_data, bus_a.grant_id, bus_a.busy, bus_a.sent_cnt, bus_a.req_ready);
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] word;
        int wait_n;
        word = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        bus_a.req_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        bus_a.req_data[2*DW +: DW] = word;
        bus_a.req_valid = 4'b0100;
        bus_a.tx_ready  = 1'b1;
        #1;
        n_checks++;
        if (bus_a.req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL single_ready: got %b want 0100", bus_a.req_ready);
        end
        @(negedge clk);
        bus_a.req_valid = '0;
        #1;
        n_checks++;
        if ({bus_a.tx_valid, bus_a.tx_data, bus_a.grant_id, bus_a.busy, bus_a.req_ready} !== {1'b1, word, 2'd2, 1'b1, 4'b0}) begin
            n_fail++;
            $display("FAIL single_send: valid=%b data=%h grant=%0d busy=%b ready=%b want 1 %h 2 1 0000",
                     bus_a.tx_valid, bus_a.tx_data, bus_a.grant_id, bus_a.busy, bus_a.req_ready, word);
        end
        @(negedge clk);
        n_checks++;
        if ({bus_a.tx_valid, bus_a.sent_cnt, bus_a.busy} !== {1'b0, 16'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL single_pushed: valid=%b cnt=%0d busy=%b want 0 1 1", bus_a.tx_valid, bus_a.sent_cnt, bus_a.busy);
        end
        // Next requester is ready immediately; the grant must wait out the gap
        bus_a.req_valid = 4'b0010;
        wait_n = 1;
        while (wait_n <= 20) begin
            #1;
            if (|bus_a.req_ready) break;
            @(negedge clk);
            wait_n++;
        end
        n_checks++;
        if (wait_n != int'(GAP_A) + 1) begin
            n_fail++; $display("FAIL single_gap: next grant after %0d cycles want %0d", wait_n, GAP_A + 1);
        end
        n_checks++;
        if (bus_a.req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL single_gap_ready: got %b want 0010", bus_a.req_ready);
        end
        @(negedge clk);
        bus_a.req_valid = '0;
    endtask

    task automatic test_fairness();
        int rr, nxt, upd, w, pushes;
        logic [DW-1:0] nxt_word;
        do_reset();
        for (int i = 0; i < int'(NR); i++) wd_b[i] = {$urandom, $urandom};
        rr = 0; nxt = -1; upd = -1; pushes = 0; nxt_word = '0;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            if (upd >= 0) begin wd_b[upd] = {$urandom, $urandom}; upd = -1; end
            n_checks++;
            if (bus_b.tx_valid !== (c % 2 == 1)) begin
                n_fail++; $display("FAIL fair_valid c=%0d: got %b want %b", c, bus_b.tx_valid, (c % 2 == 1));
            end
            if (c % 2 == 1) begin
                n_checks++;
                if ({bus_b.grant_id, bus_b.tx_data} !== {2'(nxt), nxt_word}) begin
                    n_fail++;
                    $display("FAIL fair_grant c=%0d: got id %0d data %h want id %0d data %h",
                             c, bus_b.grant_id, bus_b.tx_data, nxt, nxt_word);
                end
                rr = rr_next(nxt, rr);
                pushes++;
            end
            if (c == 12) begin
                n_checks++;
                if (bus_b.sent_cnt !== 16'd6) begin
                    n_fail++; $display("FAIL fair_count: got %0d want 6", bus_b.sent_cnt);
                end
                bus_b.req_valid = '0;
            end else begin
                bus_b.req_valid = 4'b1111;
                drive_b();
                #1;
                w = (c % 2 == 0) ? pick(4'b1111, rr) : -1;
                n_checks++;
                if (bus_b.req_ready !== onehot(w)) begin
                    n_fail++; $display("FAIL fair_ready c=%0d: got %b want %b", c, bus_b.req_ready, onehot(w));
                end
                if (w >= 0) begin nxt = w; nxt_word = wd_b[w]; upd = w; end
            end
        end
    endtask

    task automatic test_backpressure();
        int w, w2;
        do_reset();
        for (int i = 0; i < int'(NR); i++) wd_b[i] = {$urandom, $urandom};
        @(negedge clk);
        bus_b.tx_ready  = 1'b0;
        bus_b.req_valid = 4'b1010;
        drive_b();
        #1;
        w = pick(4'b1010, 0);
        n_checks++;
        if (bus_b.req_ready !== onehot(w)) begin
            n_fail++; $display("FAIL bp_ready: got %b want %b", bus_b.req_ready, onehot(w));
        end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus_b.req_valid = 4'b1010 & ~onehot(w);
            #1;
            n_checks++;
            if ({bus_b.tx_valid, bus_b.grant_id, bus_b.tx_data, bus_b.req_ready, bus_b.sent_cnt} !==
                {1'b1, 2'(w), wd_b[w], 4'b0, 16'd0}) begin
                n_fail++;
                $display("FAIL bp_hold c=%0d: valid=%b id=%0d data=%h ready=%b cnt=%0d want 1 %0d %h 0000 0",
                         c, bus_b.tx_valid, bus_b.grant_id, bus_b.tx_data, bus_b.req_ready, bus_b.sent_cnt, w, wd_b[w]);
            end
        end
        bus_b.tx_ready = 1'b1;
        @(negedge clk);
        #1;
        w2 = pick(4'b1010 & ~onehot(w), rr_next(w, 0));
        n_checks++;
        if ({bus_b.tx_valid, bus_b.sent_cnt, bus_b.req_ready} !== {1'b0, 16'd1, onehot(w2)}) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b cnt=%0d ready=%b want 0 1 %b",
                     bus_b.tx_valid, bus_b.sent_cnt, bus_b.req_ready, onehot(w2));
        end
        @(negedge clk);
        bus_b.req_valid = '0;
    endtask

    task automatic test_priority();
        int rr, w, tries;
        do_reset();
        for (int i = 0; i < int'(NR); i++) wd_b[i] = {$urandom, $urandom};
        @(negedge clk);
        bus_b.req_valid = 4'b0100;
        drive_b();
        @(negedge clk);
        bus_b.req_valid = '0;
        @(negedge clk);
        rr = rr_next(2, 0);
        for (int g = 0; g < 3; g++) begin
            tries = 0;
            do begin
                @(negedge clk);
                bus_b.req_valid = 4'b1001;
                drive_b();
                #1;
                tries++;
            end while (bus_b.req_ready == '0 && tries < 8);
            w = pick(4'b1001, rr);
            n_checks++;
            if (bus_b.req_ready !== onehot(w)) begin
                n_fail++; $display("FAIL prio_grant g=%0d: got %b want %b", g, bus_b.req_ready, onehot(w));
            end
            rr = rr_next(w, rr);
            wd_b[w] = {$urandom, $urandom};
        end
        @(negedge clk);
        bus_b.req_valid = '0;
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        for (int i = 0; i < int'(NR); i++) wd_b[i] = {$urandom, $urandom};
        @(negedge clk);
        bus_b.req_valid = 4'b0010;
        drive_b();
        @(negedge clk);
        bus_b.req_valid = '0;
        @(negedge clk);
        bus_b.tx_ready  = 1'b0;
        bus_b.req_valid = 4'b0100;
        #1;
        n_checks++;
        if (bus_b.req_ready !== onehot(pick(4'b0100, rr_next(1, 0)))) begin
            n_fail++; $display("FAIL rst_pre_ready: got %b want 0100", bus_b.req_ready);
        end
        @(negedge clk);
        bus_b.req_valid = 4'b1101;
        n_checks++;
        if ({bus_b.tx_valid, bus_b.sent_cnt} !== {1'b1, 16'd1}) begin
            n_fail++; $display("FAIL rst_pre_send: valid=%b cnt=%0d want 1 1", bus_b.tx_valid, bus_b.sent_cnt);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus_b.tx_valid, bus_b.tx_data, bus_b.grant_id, bus_b.busy, bus_b.sent_cnt, bus_b.req_ready} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: valid=%b data=%h id=%0d busy=%b cnt=%0d ready=%b want all 0",
                     bus_b.tx_valid, bus_b.tx_data, bus_b.grant_id, bus_b.busy, bus_b.sent_cnt, bus_b.req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus_b.req_ready, bus_b.sent_cnt} !== {onehot(pick(4'b1101, 0)), 16'd0}) begin
            n_fail++;
            $display("FAIL rst_restart: ready=%b cnt=%0d want %b 0", bus_b.req_ready, bus_b.sent_cnt, onehot(pick(4'b1101, 0)));
        end
        @(negedge clk);
        bus_b.req_valid = '0;
        bus_b.tx_ready  = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clk);
        force dut_b.sent_cnt_q = 16'hFFFF;
        #1;
        release dut_b.sent_cnt_q;
        n_checks++;
        if (bus_b.sent_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL wrap_preload: got %h want ffff", bus_b.sent_cnt);
        end
        wd_b[0] = {$urandom, $urandom};
        drive_b();
        bus_b.req_valid = 4'b0001;
        @(negedge clk);
        bus_b.req_valid = '0;
        @(negedge clk);
        n_checks++;
        if ({bus_b.tx_valid, bus_b.sent_cnt} !== {1'b0, 16'd0}) begin
            n_fail++; $display("FAIL wrap: valid=%b cnt=%h want 0 0000", bus_b.tx_valid, bus_b.sent_cnt);
        end
    endtask

    task automatic test_random();
        logic [NR-1:0] v;
        logic          tr, m_hold;
        int            m_id, m_rr, m_gap, w;
        logic [DW-1:0] m_word;
        logic [15:0]   m_cnt;
        do_reset();
        v = '0; m_hold = 1'b0; m_id = 0; m_rr = 0; m_gap = 0; m_word = '0; m_cnt = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            n_checks++;
            if ({bus_b.tx_valid, bus_b.sent_cnt, bus_b.busy} !== {m_hold, m_cnt, (m_hold || m_gap > 0)}) begin
                n_fail++;
                $display("FAIL rand_state c=%0d: valid=%b cnt=%0d busy=%b want %b %0d %b",
                         c, bus_b.tx_valid, bus_b.sent_cnt, bus_b.busy, m_hold, m_cnt, (m_hold || m_gap > 0));
            end
            if (m_hold) begin
                n_checks++;
                if ({bus_b.grant_id, bus_b.tx_data} !== {2'(m_id), m_word}) begin
                    n_fail++;
                    $display("FAIL rand_word c=%0d: id=%0d data=%h want %0d %h", c, bus_b.grant_id, bus_b.tx_data, m_id, m_word);
                end
            end
            tr = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < int'(NR); i++) begin
                if (v[i]) begin
                    if ($urandom_range(0, 31) == 0) v[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    v[i] = 1'b1;
                    wd_b[i] = {$urandom, $urandom};
                end
            end
            bus_b.tx_ready  = tr;
            bus_b.req_valid = v;
            drive_b();
            #1;
            w = (!m_hold && m_gap == 0) ? pick(v, m_rr) : -1;
            n_checks++;
            if (bus_b.req_ready !== onehot(w)) begin
                n_fail++; $display("FAIL rand_ready c=%0d: got %b want %b", c, bus_b.req_ready, onehot(w));
            end
            if (m_hold) begin
                if (tr) begin
                    m_hold = 1'b0; m_cnt = m_cnt + 16'd1; m_rr = rr_next(m_id, m_rr); m_gap = int'(GAP_B);
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (w >= 0) begin
                m_hold = 1'b1; m_id = w; m_word = wd_b[w]; v[w] = 1'b0;
            end
        end
        @(negedge clk);
        bus_b.req_valid = '0;
        bus_b.tx_ready  = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.req_valid = '0; bus_a.req_data = '0; bus_a.tx_ready = 1'b1;
        bus_b.req_valid = '0; bus_b.req_data = '0; bus_b.tx_ready = 1'b1;
        for (int i = 0; i < int'(NR); i++) wd_b[i] = '0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_priority();
        test_reset_mid_send();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
